// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_CMD   = 3'd0,
    ST_ADDR  = 3'd1,
    ST_COUNT = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_RUN   = 3'd5
  } state_t;

  // Command byte layout.
  localparam int GO_BIT  = 7;
  localparam int TGT_BIT = 0;

  // Write targets.
  localparam logic TGT_IMEM = 1'b0;
  localparam logic TGT_DMEM = 1'b1;

  // A command byte with any reserved bit (6:1) set is illegal.
  function automatic logic cmd_reserved_set(input logic [7:0] cmd);
    return |cmd[6:1];
  endfunction

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Little-endian 4-byte assembler: the first byte pushed lands in bits 7:0.
// word_next_o is the word as it will look after the current push, so a
// consumer can capture the complete word on the same edge as the 4th byte.
module byte_assembler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_next_o,
  output logic        word_done_o
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;

  assign word_next_o = {byte_i, word_q[31:8]};
  assign word_done_o = push_i && !clr_i && (idx_q == 2'd3);

  // Shift register and byte index; clear restarts a word at index 0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (clr_i) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (push_i) begin
      word_q <= word_next_o;
      idx_q  <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: parses CMD/ADDR/COUNT/DATA frames from a byte stream,
// writes 32-bit words into instruction or data memory, and releases the CPU
// with a sticky start once a GO command arrives.
//
// Byte handshake: a byte transfers on a rising clk_i edge where rx_valid_i
// and rx_ready_o are both high. rx_valid_i may drop at any time without
// effect; rx_ready_o depends only on state, never on rx_valid_i.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMEM_AW    = 8,
  parameter int DMEM_WORDS = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_valid_i,
  output logic               rx_ready_o,
  output logic               mem_we_o,
  output logic               mem_sel_o,
  output logic [IMEM_AW-1:0] mem_addr_o,
  output logic [31:0]        mem_data_o,
  output logic               start_o,
  output logic               busy_o,
  output logic               err_o,
  output state_t             dbg_state_o
);

  localparam logic [IMEM_AW:0] DMEM_LIMIT = (IMEM_AW+1)'(DMEM_WORDS);

  state_t             state_q, state_d;
  logic               hs;
  logic               tgt_q;
  logic [IMEM_AW-1:0] addr_q;
  logic [7:0]         cnt_q;
  logic               err_q;
  logic               start_q;
  logic               sel_q;
  logic [IMEM_AW-1:0] maddr_q;
  logic [31:0]        mdata_q;
  logic               dmem_oob;
  logic               asm_push;
  logic               asm_clr;
  logic [31:0]        asm_word_next;
  logic               asm_done;

  assign hs       = rx_valid_i && rx_ready_o;
  assign asm_push = (state_q == ST_DATA) && hs;
  assign asm_clr  = (state_q == ST_COUNT) && hs;

  // A DMEM write beyond the data-memory depth is dropped and flagged.
  assign dmem_oob = (sel_q == TGT_DMEM) && ({1'b0, maddr_q} >= DMEM_LIMIT);

  byte_assembler u_asm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (asm_clr),
    .push_i      (asm_push),
    .byte_i      (rx_data_i),
    .word_next_o (asm_word_next),
    .word_done_o (asm_done)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_CMD;
    else        state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    rx_ready_o = 1'b0;
    busy_o     = 1'b0;
    mem_we_o   = 1'b0;
    case (state_q)
      ST_CMD: begin
        rx_ready_o = 1'b1;
        if (hs) begin
          if (rx_data_i[GO_BIT])                state_d = ST_RUN;
          else if (!cmd_reserved_set(rx_data_i)) state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        rx_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (hs) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        rx_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (hs) state_d = (rx_data_i == 8'd0) ? ST_CMD : ST_DATA;
      end
      ST_DATA: begin
        rx_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (asm_done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        busy_o   = 1'b1;
        mem_we_o = !dmem_oob;
        state_d  = (cnt_q == 8'd1) ? ST_CMD : ST_DATA;
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_CMD;
      end
    endcase
  end

  // Frame registers, write-port holding registers and sticky flags.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tgt_q   <= TGT_IMEM;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      sel_q   <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
    end else begin
      case (state_q)
        ST_CMD: begin
          if (hs) begin
            if (rx_data_i[GO_BIT])                start_q <= 1'b1;
            else if (cmd_reserved_set(rx_data_i)) err_q   <= 1'b1;
            else                                  tgt_q   <= rx_data_i[TGT_BIT];
          end
        end
        ST_ADDR: begin
          if (hs) addr_q <= IMEM_AW'(rx_data_i);
        end
        ST_COUNT: begin
          if (hs) cnt_q <= rx_data_i;
        end
        ST_DATA: begin
          if (asm_done) begin
            sel_q   <= tgt_q;
            maddr_q <= addr_q;
            mdata_q <= asm_word_next;
          end
        end
        ST_WRITE: begin
          addr_q <= addr_q + 1'b1;
          cnt_q  <= cnt_q - 8'd1;
          if (dmem_oob) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_sel_o   = sel_q;
  assign mem_addr_o  = maddr_q;
  assign mem_data_o  = mdata_q;
  assign start_o     = start_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule
